// File: rtl/cam_learn_ctrl.sv
// cam_learn_ctrl: request-side controller for a 256x16 CAM with learn-on-miss.
// Latency: 2 cycles accept->resp_valid on hit/no-learn miss, 3 cycles on insert.
// Backpressure: one request in flight; req_ready low until the response is taken;
//   resp_* held stable while resp_ready is low.
// Ports: req_* / learn_en / flush in (request side), resp_* out (response side),
//   cam_* out to the CAM search/write ports, cam_match/cam_match_addr back from the CAM.
module cam_learn_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              learn_en,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_key,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_hit,
  output logic              resp_new,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              cam_enable,
  output logic [DATA_W-1:0] cam_data,
  output logic              cam_match_en,
  output logic              cam_write_en,
  output logic [ADDR_W-1:0] cam_write_addr,
  input  logic              cam_match,
  input  logic [ADDR_W-1:0] cam_match_addr
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEARCH = 3'd1,
    S_RESULT = 3'd2,
    S_WRITE  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   key_q;
  logic                learn_q;
  // One extra bit so the count can represent "all DEPTH entries written".
  logic [ADDR_W:0]     fill_cnt;
  logic                full;
  logic [ADDR_W-1:0]   victim_ptr;
  logic                valid_hit;
  logic [ADDR_W-1:0]   ins_addr;

  // The CAM returns the lowest matching address, and valid entries always
  // occupy [0, fill_cnt) until full, so a match at or beyond fill_cnt can only
  // be a stale entry left over from before a flush or reset.
  assign valid_hit = cam_match && (full || ({1'b0, cam_match_addr} < fill_cnt));
  assign ins_addr  = full ? victim_ptr : fill_cnt[ADDR_W-1:0];
  assign cam_data  = key_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = S_SEARCH;
      S_SEARCH: state_d = S_RESULT;
      S_RESULT: begin
        if (valid_hit)    state_d = S_RESP;
        else if (learn_q) state_d = S_WRITE;
        else              state_d = S_RESP;
      end
      S_WRITE:  state_d = S_RESP;
      S_RESP:   if (resp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    cam_enable     = 1'b1;
    cam_match_en   = 1'b0;
    cam_write_en   = 1'b0;
    cam_write_addr = '0;
    case (state_q)
      S_IDLE: begin
        req_ready  = 1'b1;
        cam_enable = 1'b0;
      end
      S_SEARCH: cam_match_en = 1'b1;
      S_WRITE: begin
        cam_write_en   = 1'b1;
        cam_write_addr = ins_addr;
      end
      S_RESP:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latched request, fill tracking, registered response fields
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q      <= '0;
      learn_q    <= 1'b0;
      fill_cnt   <= '0;
      full       <= 1'b0;
      victim_ptr <= '0;
      resp_hit   <= 1'b0;
      resp_new   <= 1'b0;
      resp_addr  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            key_q   <= req_key;
            learn_q <= learn_en;
          end else if (flush) begin
            fill_cnt   <= '0;
            full       <= 1'b0;
            victim_ptr <= '0;
          end
        end
        S_RESULT: begin
          if (valid_hit) begin
            resp_hit  <= 1'b1;
            resp_new  <= 1'b0;
            resp_addr <= cam_match_addr;
          end else begin
            resp_hit  <= 1'b0;
            resp_new  <= 1'b0;
            resp_addr <= '0;
          end
        end
        S_WRITE: begin
          resp_new  <= 1'b1;
          resp_addr <= ins_addr;
          if (full) begin
            victim_ptr <= (victim_ptr == ADDR_W'(DEPTH-1)) ? '0 : victim_ptr + ADDR_W'(1);
          end else begin
            fill_cnt <= fill_cnt + (ADDR_W+1)'(1);
            if (fill_cnt == (ADDR_W+1)'(DEPTH-1)) full <= 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_hit  <= 1'b0;
            resp_new  <= 1'b0;
            resp_addr <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_learn_ctrl.sv
// Testbench for cam_learn_ctrl: behavioural CAM plus a table-based reference
// of the learn/fill/victim rules; directed steps followed by random traffic.
module tb_cam_learn_ctrl;
  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flush, learn_en, req_valid, resp_ready;
  logic [DW-1:0] req_key;
  logic          req_ready, resp_valid, resp_hit, resp_new;
  logic [AW-1:0] resp_addr;
  logic          cam_enable, cam_match_en, cam_write_en;
  logic [DW-1:0] cam_data;
  logic [AW-1:0] cam_write_addr;
  logic          cam_match;
  logic [AW-1:0] cam_match_addr;

  int total = 0;
  int bad   = 0;

  cam_learn_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .learn_en(learn_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_new(resp_new), .resp_addr(resp_addr),
    .cam_enable(cam_enable), .cam_data(cam_data), .cam_match_en(cam_match_en),
    .cam_write_en(cam_write_en), .cam_write_addr(cam_write_addr),
    .cam_match(cam_match), .cam_match_addr(cam_match_addr)
  );

  // ---------------- behavioural CAM (contents survive flush/reset) ----------
  logic [DW-1:0] cam_mem [DEPTH];
  bit            cam_written [DEPTH];
  int            wr_pulses = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [DW-1:0] last_wr_data = '0;

  function automatic logic [AW:0] cam_search(input logic [DW-1:0] k);
    logic [AW:0] r;
    r = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (cam_written[i] && cam_mem[i] == k) r = {1'b1, AW'(i)};
    return r;
  endfunction

  initial begin
    cam_match      = 1'b0;
    cam_match_addr = '0;
  end

  always @(posedge clk) begin
    if (cam_enable && cam_match_en) begin
      cam_match      <= cam_search(cam_data) >> AW;
      cam_match_addr <= cam_search(cam_data) & {1'b0, {AW{1'b1}}};
    end
    if (cam_enable && cam_write_en) begin
      cam_mem[cam_write_addr]     <= cam_data;
      cam_written[cam_write_addr] <= 1'b1;
      wr_pulses                   <= wr_pulses + 1;
      last_wr_addr                <= cam_write_addr;
      last_wr_data                <= cam_data;
    end
  end

  // ---------------- reference model: table of valid entries ----------------
  logic [DW-1:0] ref_keys [DEPTH];
  int            ref_cnt    = 0;
  int            ref_victim = 0;
  bit            ref_full   = 1'b0;

  task automatic ref_clear();
    ref_cnt    = 0;
    ref_victim = 0;
    ref_full   = 1'b0;
  endtask

  task automatic ref_access(input logic [DW-1:0] key, input bit learn,
                            output bit hit, output bit nw, output int addr);
    int n;
    n    = ref_full ? DEPTH : ref_cnt;
    hit  = 1'b0;
    nw   = 1'b0;
    addr = 0;
    for (int i = 0; i < n; i++)
      if (!hit && ref_keys[i] == key) begin
        hit  = 1'b1;
        addr = i;
      end
    if (!hit && learn) begin
      nw = 1'b1;
      if (ref_full) begin
        addr       = ref_victim;
        ref_victim = (ref_victim + 1) % DEPTH;
      end else begin
        addr    = ref_cnt;
        ref_cnt = ref_cnt + 1;
        if (ref_cnt == DEPTH) ref_full = 1'b1;
      end
      ref_keys[addr] = key;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"},  32'(req_ready), 32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_hit"},   32'(resp_hit), 32'd0);
    check({tag, "_resp_new"},   32'(resp_new), 32'd0);
    check({tag, "_resp_addr"},  32'(resp_addr), 32'd0);
    check({tag, "_cam_en"},     32'(cam_enable), 32'd0);
    check({tag, "_cam_mtch"},   32'(cam_match_en), 32'd0);
    check({tag, "_cam_we"},     32'(cam_write_en), 32'd0);
    check({tag, "_cam_wa"},     32'(cam_write_addr), 32'd0);
  endtask

  // Called just after a negedge with the DUT idle; returns just after a
  // negedge with the DUT idle again.
  task automatic do_req(input logic [DW-1:0] key, input bit learn,
                        input int hold, input bit fl);
    bit eh, en;
    int ea, lat, w0;
    ref_access(key, learn, eh, en, ea);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    w0         = wr_pulses;
    req_valid  = 1'b1;
    req_key    = key;
    learn_en   = learn;
    flush      = fl;
    resp_ready = (hold == 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    learn_en  = ~learn;
    req_key   = DW'($urandom);
    lat = 0;
    while (lat < 8) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (resp_valid) break;
    end
    flush = 1'b0;
    check("latency",  32'(lat), en ? 32'd3 : 32'd2);
    check("resp_hit", 32'(resp_hit), 32'(eh));
    check("resp_new", 32'(resp_new), 32'(en));
    check("resp_addr", 32'(resp_addr), 32'(ea));
    check("wr_pulses", 32'(wr_pulses - w0), en ? 32'd1 : 32'd0);
    if (en) begin
      check("wr_addr", 32'(last_wr_addr), 32'(ea));
      check("wr_data", 32'(last_wr_data), 32'(key));
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_hit",   32'(resp_hit), 32'(eh));
      check("bp_addr",  32'(resp_addr), 32'(ea));
      check("bp_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_valid", 32'(resp_valid), 32'd0);
    check("post_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    ref_clear();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ref_clear();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int w0;
    rst_n = 1'b0; flush = 1'b0; learn_en = 1'b0; req_valid = 1'b0;
    req_key = '0; resp_ready = 1'b1;

    do_reset();
    check_idle_outputs("reset");
    check("reset_cam_data", 32'(cam_data), 32'd0);

    // first insert, then hit on the same key
    do_req(16'hA5A5, 1'b1, 0, 1'b0);
    do_req(16'hA5A5, 1'b1, 0, 1'b0);

    // sequential inserts, hit, and a no-learn miss
    do_flush();
    do_req(16'h0001, 1'b1, 0, 1'b0);
    do_req(16'h0002, 1'b1, 0, 1'b0);
    do_req(16'h0003, 1'b1, 0, 1'b0);
    do_req(16'h0002, 1'b1, 0, 1'b0);
    do_req(16'h0009, 1'b0, 0, 1'b0);

    // stale entry hidden after flush
    do_flush();
    do_req(16'h1234, 1'b1, 0, 1'b0);
    do_flush();
    do_req(16'h1234, 1'b1, 0, 1'b0);

    // backpressure on a hit
    do_req(16'h1234, 1'b0, 5, 1'b0);

    // reset while in RESULT of an insert-bound request
    w0 = wr_pulses;
    req_valid = 1'b1; req_key = 16'hBEEF; learn_en = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("midrst");
    rst_n = 1'b1;
    ref_clear();
    @(posedge clk);
    @(negedge clk);
    check("midrst_no_write", 32'(wr_pulses - w0), 32'd0);
    do_req(16'hBEEF, 1'b1, 0, 1'b0);

    // random traffic over a small key space so hits, stale matches and flushes mix
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) do_flush();
      do_req(DW'($urandom_range(0, 23)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 2)), $urandom_range(0, 7) == 0);
    end

    // fill all entries, then wrap onto victims
    do_flush();
    for (int i = 0; i < DEPTH; i++) do_req(16'h8000 + DW'(i), 1'b1, 0, 1'b0);
    check("ref_full", 32'(ref_full), 32'd1);
    do_req(16'h9000, 1'b1, 0, 1'b0);
    do_req(16'h9001, 1'b1, 0, 1'b0);
    do_req(16'h8000, 1'b0, 0, 1'b0);
    do_req(16'h8002, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cam_learn_ctrl.md
Name: cam_learn_ctrl

Overview:
Request-side controller for the 256x16 content addressable memory. Accepts lookup keys over a valid/ready handshake and drives the CAM search port. On a hit, it returns the matching address. On a miss with learning enabled, it writes the key into the next free or round-robin victim entry and returns that address. It tracks fill level so never-written CAM entries are not reported as hits.

Parameters:
DATA_W, 16, key/CAM word width
ADDR_W, 8, CAM address width
DEPTH, 256, number of CAM entries (2**ADDR_W)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
flush  in  1  clears fill count and victim pointer (ignored unless FSM in IDLE)
learn_en  in  1  allow insert on miss; sampled with request
req_valid  in  1  request present
req_ready  out  1  controller can accept request
req_key  in  DATA_W  lookup key
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_hit  out  1  key found in a valid entry
resp_new  out  1  key was inserted by this request
resp_addr  out  ADDR_W  hit or inserted address; 0 when neither
cam_enable  out  1  to CAM enable
cam_data  out  DATA_W  to CAM data_in
cam_match_en  out  1  to CAM MatchEn
cam_write_en  out  1  to CAM WriteEn
cam_write_addr  out  ADDR_W  to CAM WriteAddr
cam_match  in  1  from CAM Match (registered in CAM)
cam_match_addr  in  ADDR_W  from CAM MatchAddr (registered in CAM)

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE. fill_cnt=0, full=0, victim_ptr=0. resp_valid/hit/new=0, resp_addr=0. All cam_* outputs 0. req_ready=1 after reset.
- cam_enable=1 in every state except IDLE. cam_data is driven from the latched key and held stable from SEARCH through WRITE.
- IDLE: req_ready=1.
  - req_valid=1: latch req_key and learn_en; go to SEARCH.
  - Else if flush=1: fill_cnt=0, full=0, victim_ptr=0.
  - req_valid has priority over flush.
- SEARCH (1 cycle): cam_match_en=1. The CAM registers its result at the end of this cycle. Go to RESULT.
- RESULT (1 cycle): sample cam_match/cam_match_addr.
  - Valid hit when cam_match=1 and (full=1 or cam_match_addr < fill_cnt). The CAM reports the lowest matching address, so a match at or above fill_cnt means no valid match exists.
  - Valid hit: resp_hit=1, resp_addr=cam_match_addr; go to RESP.
  - Miss with learn latched=1: go to WRITE.
  - Miss with learn latched=0: resp_hit=0, resp_new=0, resp_addr=0; go to RESP.
- WRITE (1 cycle): cam_write_en=1, cam_write_addr = full ? victim_ptr : fill_cnt.
  - resp_new=1, resp_addr = that same address.
  - Not full: fill_cnt+1; full is set when fill_cnt reaches DEPTH-1 (fill_cnt is ADDR_W+1 bits or saturates with the full flag).
  - Full: victim_ptr+1, wrapping DEPTH-1 -> 0.
  - Go to RESP.
- RESP: resp_valid=1; outputs held stable until resp_ready=1. On resp_valid&resp_ready, clear resp_* and go to IDLE.
- Latency from request accept edge to resp_valid: 2 cycles on hit or no-learn miss, 3 cycles on learned miss. Minimum request spacing is 4 cycles (hit) or 5 cycles (insert) with resp_ready tied high.
- req_ready=0 in all states other than IDLE. At most one request is in flight; no back-to-back overlap.
- A key inserted by request N is visible to request N+1: the CAM write lands at the edge ending WRITE, before the next SEARCH.
- Reset mid-operation: returns to IDLE immediately. Any in-flight response is discarded and no further cam_write_en pulse is issued. CAM contents are not cleared, but fill_cnt=0 makes all prior entries invisible.
- Insertion occurs only on a miss, so duplicate valid entries never arise.

Test Plan:
- After reset: req key 16'hA5A5 with learn_en=1 -> miss, WRITE at addr 0, response hit=0 new=1 addr=0 after 3 cycles; re-request 16'hA5A5 -> hit=1 new=0 addr=0 after 2 cycles.
- Insert keys 16'h0001..16'h0003 -> addrs 0,1,2. Lookup 16'h0002 -> hit addr 1. Lookup 16'h0009 with learn_en=0 -> hit=0 new=0 addr=0, and no cam_write_en pulse.
- Stale-entry masking: insert 16'h1234 (addr 0), flush, request 16'h1234 learn_en=1 -> CAM reports match addr 0 but fill_cnt=0, so treated as miss; reinserted, new=1 addr=0.
- Fill and wrap: insert 256 distinct keys -> addrs 0..255, full=1. Key 257 -> written at victim addr 0; key 258 -> addr 1. Lookup of original addr-0 key -> miss.
- Backpressure: hold resp_ready=0 for 5 cycles on a hit -> resp_valid, resp_addr, resp_hit stable, req_ready=0 throughout; release -> IDLE next cycle.
- Reset asserted during WRITE-bound request (rst_n=0 in RESULT cycle) -> no cam_write_en pulse, all outputs 0, next request with the same key misses and inserts at addr 0.
